// File: rtl/runahead_queue_if.sv
// Handshake bundle between runahead validation, the runahead queue and the issue path.
// The slave modport is the queue; the master modport is the validation/issue side.
interface runahead_queue_if;
  logic        RunaheadEnqueueValid;
  logic [15:0] RunaheadEnqueueInstruction;
  logic        RunaheadEnqueueAForward;
  logic        RunaheadEnqueueBForward;
  logic        RunaheadFlush;
  logic        RunaheadIssueReady;
  logic        RunaheadIssueValid;
  logic [15:0] RunaheadIssueInstruction;
  logic        RunaheadIssueAForward;
  logic        RunaheadIssueBForward;

  // Enqueue has no backpressure: a push is taken when the queue has room (or pops
  // in the same cycle), otherwise dropped. Issue side: a transfer happens on a
  // clk_en cycle where RunaheadIssueValid && RunaheadIssueReady.
  modport slave (
    input  RunaheadEnqueueValid, RunaheadEnqueueInstruction,
    input  RunaheadEnqueueAForward, RunaheadEnqueueBForward,
    input  RunaheadFlush, RunaheadIssueReady,
    output RunaheadIssueValid, RunaheadIssueInstruction,
    output RunaheadIssueAForward, RunaheadIssueBForward
  );

  modport master (
    output RunaheadEnqueueValid, RunaheadEnqueueInstruction,
    output RunaheadEnqueueAForward, RunaheadEnqueueBForward,
    output RunaheadFlush, RunaheadIssueReady,
    input  RunaheadIssueValid, RunaheadIssueInstruction,
    input  RunaheadIssueAForward, RunaheadIssueBForward
  );
endinterface

// File: rtl/runahead_queue.sv
// Circular replay FIFO for instructions diverted by runahead operand validation.
// Define RUNAHEAD_QUEUE_HIGHWATER_EN to add the QueueAlmostFull output.
module runahead_queue #(
  parameter int DEPTH      = 8,
  parameter int HIGH_WATER = 6
) (
  input  logic                   clk,
  input  logic                   clk_en,
  input  logic                   sync_rst,
  runahead_queue_if.slave        ifc,
  output logic [$clog2(DEPTH):0] QueueCount,
  output logic                   QueueFull,
  output logic                   QueueOverflow
`ifdef RUNAHEAD_QUEUE_HIGHWATER_EN
  ,
  output logic                   QueueAlmostFull
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("runahead_queue: DEPTH must be a power of two >= 2");
  end
  if ((HIGH_WATER < 1) || (HIGH_WATER > DEPTH)) begin : g_bad_high_water
    $error("runahead_queue: HIGH_WATER must lie in 1..DEPTH");
  end

  logic [17:0]   mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic full;
  logic pop;
  logic push;
  logic flush_en;
  logic [17:0] head_entry;

  assign full       = (count_q == CW'(DEPTH));
  assign head_entry = mem_q[head_q];
  assign flush_en   = ifc.RunaheadFlush && clk_en;
  assign pop        = (count_q != '0) && ifc.RunaheadIssueReady && clk_en;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push       = ifc.RunaheadEnqueueValid && clk_en && (!full || pop);

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (flush_en) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (pop)  head_d = head_q + PW'(1);
      if (push) tail_d = tail_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      if (ifc.RunaheadEnqueueValid && clk_en && !push) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (clk_en) begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (!sync_rst && !flush_en && push) begin
      mem_q[tail_q] <= {ifc.RunaheadEnqueueBForward, ifc.RunaheadEnqueueAForward,
                        ifc.RunaheadEnqueueInstruction};
    end
  end

  assign ifc.RunaheadIssueValid       = (count_q != '0);
  assign ifc.RunaheadIssueInstruction = head_entry[15:0];
  assign ifc.RunaheadIssueAForward    = head_entry[16];
  assign ifc.RunaheadIssueBForward    = head_entry[17];

  assign QueueCount    = count_q;
  assign QueueFull     = full;
  assign QueueOverflow = overflow_q;

`ifdef RUNAHEAD_QUEUE_HIGHWATER_EN
  assign QueueAlmostFull = (count_q >= CW'(HIGH_WATER));
`endif
endmodule
